// File: rtl/risc_v_mike_pkg.sv
// Shared types and encodings for the RISC-V Mike multi-cycle control unit.
package risc_v_mike_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
    S_EXEC_R, S_EXEC_I, S_ALU_WB, S_JALR, S_JAL, S_BRANCH, S_LUI,
    S_AUIPC, S_TRAP
  } t_mc_state;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
    ALU_XOR  = 4'd4, ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
    ALU_SLT  = 4'd8, ALU_SLTU = 4'd9
  } t_alu_ctrl;

  // Which kind of ALU operation the current state asks for.
  typedef enum logic [1:0] {
    ALU_CLS_ADD, ALU_CLS_SUB, ALU_CLS_R, ALU_CLS_I
  } t_alu_cls;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;
  localparam logic [1:0] SRC_A_ZERO  = 2'b11;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  // addi x0,x0,0 -- the IR holds a harmless NOP out of reset.
  localparam logic [31:0] IR_RESET_VAL = 32'h0000_0013;

  // Branch condition from funct3 and the compare flags of rs1 - rs2.
  function automatic logic branch_taken(input logic [2:0] f3, input logic zero,
                                        input logic lt, input logic ltu);
    case (f3)
      3'b000:  branch_taken = zero;
      3'b001:  branch_taken = ~zero;
      3'b100:  branch_taken = lt;
      3'b101:  branch_taken = ~lt;
      3'b110:  branch_taken = ltu;
      3'b111:  branch_taken = ~ltu;
      default: branch_taken = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/risc_v_mike_mc_ctrl_alu_dec.sv
// ALU control decode: state class, funct3 and funct7[5] to alu_ctrl.
module risc_v_mike_mc_ctrl_alu_dec
  import risc_v_mike_pkg::*;
(
  input  t_alu_cls   alu_cls,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output t_alu_ctrl  alu_ctrl
);

  // funct7[5] picks SUB only for register ops; SRA for both R and I shifts.
  always_comb begin
    alu_ctrl = ALU_ADD;
    case (alu_cls)
      ALU_CLS_ADD: alu_ctrl = ALU_ADD;
      ALU_CLS_SUB: alu_ctrl = ALU_SUB;
      default: begin
        case (funct3)
          3'b000:  alu_ctrl = ((alu_cls == ALU_CLS_R) && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_ctrl = ALU_SLL;
          3'b010:  alu_ctrl = ALU_SLT;
          3'b011:  alu_ctrl = ALU_SLTU;
          3'b100:  alu_ctrl = ALU_XOR;
          3'b101:  alu_ctrl = funct7_5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_ctrl = ALU_OR;
          default: alu_ctrl = ALU_AND;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/risc_v_mike_mc_ctrl.sv
// Multi-cycle control unit for the RISC-V Mike core: instruction register
// plus Moore FSM sequencing the shared PC/ALU/memory datapath.
// Optional: RISC_V_MIKE_ILLEGAL_TRAP_EN sends unknown opcodes and reserved
// branch funct3 values to an absorbing TRAP state with a sticky illegal flag.
//
// state     | meaning
// FETCH     | read instruction at PC, PC <= PC+4 on mem_ready
// DECODE    | ALUOut <= oldPC + imm (branch/jump target)
// MEM_ADR   | ALUOut <= rs1 + imm
// MEM_READ  | load request at ALUOut
// MEM_WB    | rd <= memory data
// MEM_WRITE | store request at ALUOut
// EXEC_R    | ALUOut <= rs1 op rs2
// EXEC_I    | ALUOut <= rs1 op imm
// ALU_WB    | rd <= ALUOut
// JALR      | ALUOut <= rs1 + imm, then shares JAL
// JAL       | PC <= ALUOut, ALUOut <= oldPC+4
// BRANCH    | compare rs1/rs2, PC <= ALUOut if taken
// LUI       | ALUOut <= imm
// AUIPC     | ALUOut <= oldPC + imm
// TRAP      | halted on illegal instruction until reset
module risc_v_mike_mc_ctrl
  import risc_v_mike_pkg::*;
#(
  parameter int INSTR_W    = 32,
  parameter int ALU_CTRL_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_ready,
  input  logic [INSTR_W-1:0]    instruction,
  input  logic                  alu_zero,
  input  logic                  alu_lt,
  input  logic                  alu_ltu,
  output logic                  mem_req,
  output logic                  mem_write,
  output logic                  adr_src,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic                  reg_write,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            result_src,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic [2:0]            imm_src,
  output logic [4:0]            rs1,
  output logic [4:0]            rs2,
  output logic [4:0]            rsd,
  output logic [2:0]            funct3,
  output logic                  illegal
);

  t_mc_state          state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [6:0]         opcode;
  logic               mem_req_c, mem_write_c, ir_write_c, pc_write_c, reg_write_c;
  t_alu_cls           alu_cls;
  t_alu_ctrl          alu_dec_ctrl;
  logic               unused_ir_bits;

  assign opcode = ir_q[6:0];
  assign rsd    = ir_q[11:7];
  assign funct3 = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign unused_ir_bits = ^{ir_q[INSTR_W-1:31], ir_q[29:25]};

  // Instruction register loads on a completed fetch.
  assign ir_d = ir_write_c ? instruction : ir_q;

  // State and IR registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      ir_q    <= INSTR_W'(IR_RESET_VAL);
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Next state and Moore datapath controls.
  always_comb begin
    state_d     = state_q;
    mem_req_c   = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    reg_write_c = 1'b0;
    adr_src     = 1'b0;
    alu_src_a   = SRC_A_PC;
    alu_src_b   = SRC_B_RS2;
    result_src  = RES_ALUOUT;
    imm_src     = IMM_I;
    alu_cls     = ALU_CLS_ADD;
    case (state_q)
      S_FETCH: begin
        mem_req_c  = 1'b1;
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALU;
        ir_write_c = mem_ready;
        pc_write_c = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
        imm_src   = (opcode == OP_JAL) ? IMM_J : IMM_B;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEM_ADR;
          OP_R:              state_d = S_EXEC_R;
          OP_I:              state_d = S_EXEC_I;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
`ifdef RISC_V_MIKE_ILLEGAL_TRAP_EN
          OP_BRANCH:         state_d = (funct3[2:1] == 2'b01) ? S_TRAP : S_BRANCH;
`else
          OP_BRANCH:         state_d = S_BRANCH;
`endif
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_AUIPC;
`ifdef RISC_V_MIKE_ILLEGAL_TRAP_EN
          default:           state_d = S_TRAP;
`else
          default:           state_d = S_FETCH;
`endif
        endcase
      end
      S_MEM_ADR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        imm_src   = (opcode == OP_STORE) ? IMM_S : IMM_I;
        state_d   = (opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        mem_req_c = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        result_src  = RES_MEM;
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_req_c   = 1'b1;
        mem_write_c = 1'b1;
        adr_src     = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a = SRC_A_RS1;
        alu_cls   = ALU_CLS_R;
        state_d   = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        alu_cls   = ALU_CLS_I;
        state_d   = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_JALR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        state_d   = S_JAL;
      end
      S_JAL: begin
        alu_src_a  = SRC_A_OLDPC;
        alu_src_b  = SRC_B_FOUR;
        pc_write_c = 1'b1;
        state_d    = S_ALU_WB;
      end
      S_BRANCH: begin
        alu_src_a  = SRC_A_RS1;
        alu_cls    = ALU_CLS_SUB;
        pc_write_c = branch_taken(funct3, alu_zero, alu_lt, alu_ltu);
        state_d    = S_FETCH;
      end
      S_LUI: begin
        alu_src_a = SRC_A_ZERO;
        alu_src_b = SRC_B_IMM;
        imm_src   = IMM_U;
        state_d   = S_ALU_WB;
      end
      S_AUIPC: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
        imm_src   = IMM_U;
        state_d   = S_ALU_WB;
      end
      default: state_d = state_q;
    endcase
  end

  // Enables are killed combinationally while reset is held.
  assign mem_req   = mem_req_c   & ~rst;
  assign mem_write = mem_write_c & ~rst;
  assign ir_write  = ir_write_c  & ~rst;
  assign pc_write  = pc_write_c  & ~rst;
  assign reg_write = reg_write_c & ~rst;

  risc_v_mike_mc_ctrl_alu_dec u_alu_dec (
    .alu_cls  (alu_cls),
    .funct3   (funct3),
    .funct7_5 (ir_q[30]),
    .alu_ctrl (alu_dec_ctrl)
  );

  assign alu_ctrl = ALU_CTRL_W'(alu_dec_ctrl);

`ifdef RISC_V_MIKE_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  assign illegal_d = illegal_q | (state_d == S_TRAP);

  // Sticky illegal flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) illegal_q <= 1'b0;
    else     illegal_q <= illegal_d;
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_risc_v_mike_mc_ctrl.sv
// Directed bench for risc_v_mike_mc_ctrl.
module tb_risc_v_mike_mc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_ready;
  logic [31:0] instruction;
  logic        alu_zero, alu_lt, alu_ltu;
  logic        mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0]  alu_src_a, alu_src_b, result_src;
  logic [3:0]  alu_ctrl;
  logic [2:0]  imm_src;
  logic [4:0]  rs1, rs2, rsd;
  logic [2:0]  funct3;
  logic        illegal;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  risc_v_mike_mc_ctrl dut (
    .clk(clk), .rst(rst), .mem_ready(mem_ready), .instruction(instruction),
    .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu),
    .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
    .alu_ctrl(alu_ctrl), .imm_src(imm_src), .rs1(rs1), .rs2(rs2), .rsd(rsd),
    .funct3(funct3), .illegal(illegal)
  );

  wire [31:0] sig_obs = {13'd0, mem_req, mem_write, adr_src, ir_write, pc_write,
                         reg_write, alu_src_a, alu_src_b, result_src, alu_ctrl, imm_src};
  wire [31:0] fld_obs = {14'd0, rs1, rs2, rsd, funct3};

  function automatic logic [31:0] sg(input int mreq, input int mw, input int adr,
                                     input int irw, input int pcw, input int rw,
                                     input int a, input int b, input int rs,
                                     input int alu, input int imm);
    sg = {13'd0, mreq[0], mw[0], adr[0], irw[0], pcw[0], rw[0],
          a[1:0], b[1:0], rs[1:0], alu[3:0], imm[2:0]};
  endfunction

  function automatic logic [31:0] fl(input int r1, input int r2, input int rd, input int f3);
    fl = {14'd0, r1[4:0], r2[4:0], rd[4:0], f3[2:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic step_chk(input string tag, input logic [31:0] exp);
    tick();
    settle();
    check(tag, sig_obs, exp);
  endtask

  task automatic fetch(input logic [31:0] instr);
    tick();
    instruction = instr;
    mem_ready   = 1'b1;
    settle();
    check("fetch", sig_obs, sg(1,0,0,1,1,0, 0,2,2,0,0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] dec_b, awb, fr;
    dec_b = sg(0,0,0,0,0,0, 1,1,0,0,2);
    awb   = sg(0,0,0,0,0,1, 0,0,0,0,0);
    fr    = sg(0,0,0,0,0,0, 0,2,2,0,0);

    rst = 1'b1; mem_ready = 1'b1; instruction = 32'h0;
    alu_zero = 1'b0; alu_lt = 1'b0; alu_ltu = 1'b0;
    tick();
    settle();
    check("reset_sig", sig_obs, fr);
    check("reset_fields", fld_obs, fl(0,0,0,0));
    check("reset_illegal", {31'd0, illegal}, 32'd0);

    rst = 1'b0; mem_ready = 1'b0;
    settle();
    check("fetch_wait", sig_obs, sg(1,0,0,0,0,0, 0,2,2,0,0));

    // add x3,x1,x2
    fetch(32'h002081B3);
    step_chk("add_dec", dec_b);
    check("add_fields", fld_obs, fl(1,2,3,0));
    step_chk("add_exr", sg(0,0,0,0,0,0, 2,0,0,0,0));
    step_chk("add_wb", awb);

    // sub x3,x1,x2
    fetch(32'h402081B3);
    step_chk("sub_dec", dec_b);
    step_chk("sub_exr", sg(0,0,0,0,0,0, 2,0,0,1,0));
    step_chk("sub_wb", awb);

    // srai x1,x1,3
    fetch(32'h4030D093);
    step_chk("srai_dec", dec_b);
    step_chk("srai_exi", sg(0,0,0,0,0,0, 2,1,0,7,0));
    step_chk("srai_wb", awb);

    // addi x1,x1,-1024 (bit 30 set, must stay ADD)
    fetch(32'hC0008093);
    step_chk("addi_dec", dec_b);
    step_chk("addi_exi", sg(0,0,0,0,0,0, 2,1,0,0,0));
    step_chk("addi_wb", awb);

    // lw x5,8(x1) with three wait cycles in MEM_READ
    fetch(32'h0080A283);
    step_chk("lw_dec", dec_b);
    check("lw_fields", fld_obs, fl(1,8,5,2));
    step_chk("lw_madr", sg(0,0,0,0,0,0, 2,1,0,0,0));
    for (int i = 0; i < 3; i++) begin
      tick();
      mem_ready = 1'b0;
      settle();
      check("lw_mrd_wait", sig_obs, sg(1,0,1,0,0,0, 0,0,0,0,0));
    end
    tick();
    mem_ready = 1'b1;
    settle();
    check("lw_mrd_done", sig_obs, sg(1,0,1,0,0,0, 0,0,0,0,0));
    step_chk("lw_mwb", sg(0,0,0,0,0,1, 0,0,1,0,0));

    // blt x1,x2 taken / not taken
    alu_lt = 1'b1;
    fetch(32'h0020C063);
    step_chk("blt_dec", dec_b);
    step_chk("blt_taken", sg(0,0,0,0,1,0, 2,0,0,1,0));
    alu_lt = 1'b0;
    fetch(32'h0020C063);
    step_chk("blt_dec2", dec_b);
    step_chk("blt_not_taken", sg(0,0,0,0,0,0, 2,0,0,1,0));

    // bgeu with ltu=0 taken
    alu_ltu = 1'b0;
    fetch(32'h0020F063);
    step_chk("bgeu_dec", dec_b);
    step_chk("bgeu_taken", sg(0,0,0,0,1,0, 2,0,0,1,0));

    // bne with zero=1 not taken
    alu_zero = 1'b1;
    fetch(32'h00209063);
    step_chk("bne_dec", dec_b);
    step_chk("bne_not_taken", sg(0,0,0,0,0,0, 2,0,0,1,0));

`ifndef RISC_V_MIKE_ILLEGAL_TRAP_EN
    // reserved branch funct3 010 never taken, even with all flags set
    alu_lt = 1'b1; alu_ltu = 1'b1;
    fetch(32'h0020A063);
    step_chk("b010_dec", dec_b);
    step_chk("b010_not_taken", sg(0,0,0,0,0,0, 2,0,0,1,0));
`endif
    alu_zero = 1'b0; alu_lt = 1'b0; alu_ltu = 1'b0;

    // jalr x1,0(x2)
    fetch(32'h000100E7);
    step_chk("jalr_dec", dec_b);
    step_chk("jalr_jalr", sg(0,0,0,0,0,0, 2,1,0,0,0));
    step_chk("jalr_jal", sg(0,0,0,0,1,0, 1,2,0,0,0));
    step_chk("jalr_wb", awb);

    // jal x1,0 uses J immediate in DECODE
    fetch(32'h000000EF);
    step_chk("jal_dec", sg(0,0,0,0,0,0, 1,1,0,0,4));
    step_chk("jal_jal", sg(0,0,0,0,1,0, 1,2,0,0,0));
    step_chk("jal_wb", awb);

    // lui / auipc
    fetch(32'h123452B7);
    step_chk("lui_dec", dec_b);
    step_chk("lui_exe", sg(0,0,0,0,0,0, 3,1,0,0,3));
    step_chk("lui_wb", awb);
    fetch(32'h12345297);
    step_chk("auipc_dec", dec_b);
    step_chk("auipc_exe", sg(0,0,0,0,0,0, 1,1,0,0,3));
    step_chk("auipc_wb", awb);

    // sw x2,4(x1), reset asserted mid MEM_WRITE
    fetch(32'h0020A223);
    step_chk("sw_dec", dec_b);
    step_chk("sw_madr", sg(0,0,0,0,0,0, 2,1,0,0,1));
    tick();
    mem_ready = 1'b0;
    settle();
    check("sw_mwr", sig_obs, sg(1,1,1,0,0,0, 0,0,0,0,0));
    mem_ready = 1'b1;
    rst = 1'b1;
    settle();
    check("sw_rst_sig", sig_obs, fr);
    check("sw_rst_fields", fld_obs, fl(0,0,0,0));
    tick();
    rst = 1'b0;
    mem_ready = 1'b0;
    settle();
    check("sw_rst_restart", sig_obs, sg(1,0,0,0,0,0, 0,2,2,0,0));

    // unknown opcode
    fetch(32'h0000007F);
    step_chk("ill_dec", dec_b);
`ifdef RISC_V_MIKE_ILLEGAL_TRAP_EN
    step_chk("ill_trap", sg(0,0,0,0,0,0, 0,0,0,0,0));
    check("ill_flag", {31'd0, illegal}, 32'd1);
    step_chk("ill_trap_hold", sg(0,0,0,0,0,0, 0,0,0,0,0));
    check("ill_flag_hold", {31'd0, illegal}, 32'd1);
`else
    step_chk("ill_nop_fetch", sg(1,0,0,1,1,0, 0,2,2,0,0));
    check("ill_flag", {31'd0, illegal}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
